// File: rtl/serial_adc_ctrl_if.sv
// Host-side and ADC-side signals of the serial ADC controller.
// master is the controller's view; slave is the host/ADC view.
interface serial_adc_ctrl_if #(
  parameter int DATA_BITS = 12,
  parameter int ADDR_BITS = 4
);
  logic                 start;
  logic                 continuous;
  logic [ADDR_BITS-1:0] channel;
  logic                 sdat_in;
  logic                 adc_clk;
  logic                 cs_n;
  logic                 sdat_out;
  logic                 busy;
  logic                 data_valid;
  logic [DATA_BITS-1:0] data_out;
  logic [ADDR_BITS-1:0] chan_out;

  modport master (
    input  start, continuous, channel, sdat_in,
    output adc_clk, cs_n, sdat_out, busy, data_valid, data_out, chan_out
  );

  modport slave (
    output start, continuous, channel, sdat_in,
    input  adc_clk, cs_n, sdat_out, busy, data_valid, data_out, chan_out
  );
endinterface

// File: rtl/serial_adc_ctrl.sv
// Serial ADC frame controller: chip select, divided I/O clock, MSB-first address out / result in.
// Define ADC_AUTOSCAN_EN to step the channel address on back-to-back continuous frames.
module serial_adc_ctrl #(
  parameter int DATA_BITS    = 12,
  parameter int ADDR_BITS    = 4,
  parameter int CLK_DIV      = 32,
  parameter int SETUP_TICKS  = 4,
  parameter int CONV_TICKS   = 44,
  parameter int NUM_CHANNELS = 11
) (
  input logic clock,
  input logic reset,
  serial_adc_ctrl_if.master bus
);
`ifdef ADC_AUTOSCAN_EN
  localparam bit AUTOSCAN = 1'b1;
`else
  localparam bit AUTOSCAN = 1'b0;
`endif
  localparam int DW   = $clog2(CLK_DIV);
  localparam int SMAX = (SETUP_TICKS > CONV_TICKS) ? SETUP_TICKS : CONV_TICKS;
  localparam int TMAX = (2*DATA_BITS > SMAX) ? 2*DATA_BITS : SMAX;
  localparam int TW   = $clog2(TMAX);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, CONV, LOAD} state_t;

  state_t               state;
  logic [DW-1:0]        div_cnt;
  logic                 tick;
  logic [TW-1:0]        tcnt;
  logic [1:0]           sync;
  logic [DATA_BITS-1:0] shreg;
  logic [ADDR_BITS-1:0] addr, prev_addr, aout, aout_sh, scan_next, next_addr;
  logic                 begin_frame;

  assign tick    = (div_cnt == DW'(CLK_DIV - 1));
  assign aout_sh = aout << 1;

  // Auto-scan only steps between continuous frames; leaving IDLE always takes the requested channel.
  assign scan_next   = (addr >= ADDR_BITS'(NUM_CHANNELS - 1)) ? '0 : addr + 1'b1;
  assign next_addr   = (state == IDLE || !AUTOSCAN) ? bus.channel : scan_next;
  assign begin_frame = (state == IDLE && (bus.start || bus.continuous)) ||
                       (state == LOAD && bus.continuous);

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
      sync    <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      sync    <= {sync[0], bus.sdat_in};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      tcnt           <= '0;
      shreg          <= '0;
      addr           <= '0;
      prev_addr      <= '0;
      aout           <= '0;
      bus.cs_n       <= 1'b1;
      bus.adc_clk    <= 1'b0;
      bus.sdat_out   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.data_valid <= 1'b0;
      bus.data_out   <= '0;
      bus.chan_out   <= '0;
    end else begin
      bus.data_valid <= 1'b0;
      case (state)
        IDLE: ;
        SETUP: if (tick) begin
          if (tcnt == TW'(SETUP_TICKS - 1)) begin
            state <= SHIFT;
            tcnt  <= '0;
          end else
            tcnt <= tcnt + 1'b1;
        end
        SHIFT: if (tick) begin
          bus.adc_clk <= ~bus.adc_clk;
          // Falling edge: capture the settled input bit and present the next address bit.
          if (bus.adc_clk) begin
            shreg        <= {shreg[DATA_BITS-2:0], sync[1]};
            aout         <= aout_sh;
            bus.sdat_out <= aout_sh[ADDR_BITS-1];
          end
          if (tcnt == TW'(2*DATA_BITS - 1)) begin
            state    <= CONV;
            tcnt     <= '0;
            bus.cs_n <= 1'b1;
          end else
            tcnt <= tcnt + 1'b1;
        end
        CONV: if (tick) begin
          if (tcnt == TW'(CONV_TICKS - 1)) begin
            state          <= LOAD;
            tcnt           <= '0;
            bus.data_valid <= 1'b1;
            bus.data_out   <= shreg;
            // The ADC answers one frame late, so the result belongs to the previous address.
            bus.chan_out   <= prev_addr;
          end else
            tcnt <= tcnt + 1'b1;
        end
        LOAD: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (begin_frame) begin
        state        <= SETUP;
        tcnt         <= '0;
        bus.cs_n     <= 1'b0;
        bus.busy     <= 1'b1;
        prev_addr    <= addr;
        addr         <= next_addr;
        aout         <= next_addr;
        bus.sdat_out <= next_addr[ADDR_BITS-1];
      end
    end
  end
endmodule

// File: tb/tb_serial_adc_ctrl.sv
// Randomized bench for serial_adc_ctrl: a serial ADC model plus a frame-level scoreboard.
// Build with ADC_AUTOSCAN_EN to exercise the address stepping of continuous frames.
module tb_serial_adc_ctrl;
  localparam int DB = 12, AB = 4, CD = 4, ST = 2, CT = 10, NC = 11;
  localparam int FRAME_MAX = (ST + 2*DB + CT + 2) * CD;
`ifdef ADC_AUTOSCAN_EN
  localparam bit AUTOSCAN = 1'b1;
`else
  localparam bit AUTOSCAN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  serial_adc_ctrl_if #(.DATA_BITS(DB), .ADDR_BITS(AB)) bus ();

  serial_adc_ctrl #(
    .DATA_BITS(DB), .ADDR_BITS(AB), .CLK_DIV(CD),
    .SETUP_TICKS(ST), .CONV_TICKS(CT), .NUM_CHANNELS(NC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic rst_q = 1'b1;
  always @(posedge clock) rst_q <= reset;

  // ADC model: presents a word MSB first, advancing on each adc_clk fall; records what the frame looked like.
  logic          prev_cs = 1'b1, prev_ck = 1'b0;
  logic [AB-1:0] acap;
  int word, bidx, npulse, tail_bad;
  int frames_started = 0;
  int forced_word = -1;
  int q_word[$], q_addr[$], q_pulse[$], q_tail[$];
  int exp_addr[$];

  always @(negedge clock) begin
    if (rst_q) begin
      prev_cs = 1'b1;
      prev_ck = 1'b0;
    end else begin
      if (prev_cs && !bus.cs_n) begin
        word = (forced_word >= 0) ? forced_word : int'($urandom_range(0, (1 << DB) - 1));
        bidx = 0; npulse = 0; tail_bad = 0; acap = '0;
        frames_started++;
        bus.sdat_in = word[DB-1];
      end
      if (!bus.cs_n && bus.adc_clk && !prev_ck) begin
        npulse++;
        if (npulse <= AB) acap = {acap[AB-2:0], bus.sdat_out};
        else if (bus.sdat_out) tail_bad++;
      end
      if (!bus.cs_n && !bus.adc_clk && prev_ck) begin
        bidx++;
        bus.sdat_in = (bidx < DB) ? word[DB-1-bidx] : 1'b0;
      end
      if (!prev_cs && bus.cs_n) begin
        q_word.push_back(word);
        q_addr.push_back(int'(acap));
        q_pulse.push_back(npulse);
        q_tail.push_back(tail_bad);
      end
      prev_cs = bus.cs_n;
      prev_ck = bus.adc_clk;
    end
  end

  // Scoreboard: strobe k carries frame k's word and frame k-1's address; outputs hold otherwise.
  int            strobes = 0;
  int            prev_sent = 0;
  logic [DB-1:0] last_dout = '0;
  logic [AB-1:0] last_chan = '0;

  always @(negedge clock) begin
    int w, a, p, t, ea;
    if (rst_q) begin
      prev_sent = 0; last_dout = '0; last_chan = '0;
      q_word.delete(); q_addr.delete(); q_pulse.delete(); q_tail.delete();
    end else if (bus.data_valid) begin
      strobes++;
      chk("frame_seen", q_word.size() > 0, 1);
      if (q_word.size() > 0) begin
        w = q_word.pop_front(); a = q_addr.pop_front();
        p = q_pulse.pop_front(); t = q_tail.pop_front();
        chk("data_out", bus.data_out, w);
        chk("chan_out", bus.chan_out, prev_sent);
        chk("adc_clk_pulses", p, DB);
        chk("sdat_out_tail", t, 0);
        chk("frame_expected", exp_addr.size() > 0, 1);
        ea = (exp_addr.size() > 0) ? exp_addr.pop_front() : -1;
        chk("frame_addr", a, ea);
        last_dout = DB'(w);
        last_chan = AB'(prev_sent);
        prev_sent = a;
      end
    end else
      chk("hold", {bus.chan_out, bus.data_out}, {last_chan, last_dout});
  end

  task automatic wait_strobes(input string tag, input int target, input int limit);
    int n = 0;
    while (n < limit && strobes < target) begin @(negedge clock); n++; end
    chk(tag, strobes, target);
  endtask

  task automatic wait_pulses(input string tag, input int f0, input int np, input int limit);
    int n = 0;
    while (n < limit && !(frames_started > f0 && npulse >= np)) begin @(negedge clock); n++; end
    chk(tag, frames_started > f0 && npulse >= np, 1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_cs_n"}, bus.cs_n, 1);
    chk({tag, "_adc_clk"}, bus.adc_clk, 0);
  endtask

  task automatic single_frame(input logic [AB-1:0] ch, input int fw);
    int s0 = strobes;
    forced_word = fw;
    bus.channel = ch;
    exp_addr.push_back(int'(ch));
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    wait_strobes("single_latency", s0 + 1, FRAME_MAX);
    repeat (3) @(negedge clock);
    check_idle("after_single");
  endtask

  initial begin
    int s0, f0, c, nc, prev;
    bus.start = 1'b0; bus.continuous = 1'b0; bus.channel = '0; bus.sdat_in = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_cs_n", bus.cs_n, 1);
    chk("rst_adc_clk", bus.adc_clk, 0);
    chk("rst_sdat_out", bus.sdat_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_data_valid", bus.data_valid, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_chan_out", bus.chan_out, 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // Known word on channel 5 (address bits 0101 on sdat_out).
    single_frame(4'd5, 'hA5C);
    chk("a5c_data_out", bus.data_out, 'hA5C);

    // Pipeline tag: the second result is tagged with the first frame's channel.
    forced_word = -1;
    single_frame(4'd3, -1);
    single_frame(4'd7, -1);
    chk("pipe_tag", bus.chan_out, 3);

    repeat (4) begin
      repeat ($urandom_range(0, 20)) @(negedge clock);
      single_frame(AB'($urandom_range(0, (1 << AB) - 1)), -1);
    end

    // A start pulse mid-frame must not queue a second frame.
    s0 = strobes; f0 = frames_started;
    bus.channel = AB'($urandom_range(0, NC - 1));
    exp_addr.push_back(int'(bus.channel));
    bus.start = 1'b1; @(negedge clock); bus.start = 1'b0;
    wait_pulses("reach_shift", f0, 3, FRAME_MAX);
    bus.start = 1'b1; @(negedge clock); bus.start = 1'b0;
    repeat (2 * FRAME_MAX) @(negedge clock);
    chk("start_ignored_strobes", strobes, s0 + 1);
    check_idle("after_ignored");

    // Continuous run of four frames, continuous dropped during the last conversion.
    c = AUTOSCAN ? 9 : int'($urandom_range(0, (1 << AB) - 1));
    s0 = strobes; f0 = frames_started;
    bus.channel = AB'(c);
    exp_addr.push_back(c);
    prev = c;
    bus.continuous = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_pulses("cont_frame", f0 + f, 2, 2 * FRAME_MAX);
      nc = int'($urandom_range(0, (1 << AB) - 1));
      bus.channel = AB'(nc);
      if (f < 3) begin
        prev = AUTOSCAN ? (prev + 1) % NC : nc;
        exp_addr.push_back(prev);
      end else begin
        int n = 0;
        while (n < FRAME_MAX && !bus.cs_n) begin @(negedge clock); n++; end
        chk("reach_conv", bus.cs_n, 1);
        bus.continuous = 1'b0;
      end
    end
    wait_strobes("cont_strobes", s0 + 4, 2 * FRAME_MAX);
    repeat (3) @(negedge clock);
    check_idle("after_cont");
    repeat (FRAME_MAX) @(negedge clock);
    chk("cont_no_extra", strobes, s0 + 4);

    // Reset in the middle of the shift phase aborts silently.
    f0 = frames_started;
    bus.channel = AB'($urandom_range(0, NC - 1));
    exp_addr.push_back(int'(bus.channel));
    bus.start = 1'b1; @(negedge clock); bus.start = 1'b0;
    wait_pulses("reach_bit6", f0, 6, FRAME_MAX);
    s0 = strobes;
    reset = 1'b1;
    @(negedge clock);
    check_idle("mid_reset");
    chk("mid_reset_data_out", bus.data_out, 0);
    chk("mid_reset_chan_out", bus.chan_out, 0);
    chk("mid_reset_valid", bus.data_valid, 0);
    reset = 1'b0;
    exp_addr.delete();
    repeat (FRAME_MAX) @(negedge clock);
    chk("no_strobe_after_reset", strobes, s0);

    single_frame(AB'($urandom_range(0, (1 << AB) - 1)), -1);
    chk("post_reset_chan", bus.chan_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adc_ctrl.md
SERIAL_ADC_CTRL -- requirements
Module: serial_adc_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 12, meaning conversion result width (legal 8..16).
REQ-002 SHALL have parameter ADDR_BITS, default 4, meaning channel address width (legal 1..DATA_BITS).
REQ-003 SHALL have parameter CLK_DIV, default 32, meaning system clocks per tick (legal >=2).
REQ-004 SHALL have parameters SETUP_TICKS, default 4, meaning cs_n-low-to-first-clock delay, and CONV_TICKS, default 44, meaning conversion wait.
REQ-005 SHALL have parameter NUM_CHANNELS, default 11, meaning number of channels scanned.
REQ-006 Ports SHALL be (name direction width meaning):
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  single-frame request
- continuous  in  1  back-to-back frames while high
- channel  in  ADDR_BITS  requested channel
- sdat_in  in  1  ADC serial data, MSB first
- adc_clk  out  1  ADC I/O clock
- cs_n  out  1  ADC chip select, active-low
- sdat_out  out  1  channel address to ADC, MSB first
- busy  out  1  frame in progress
- data_valid  out  1  one-cycle result strobe
- data_out  out  DATA_BITS  last result
- chan_out  out  ADDR_BITS  channel of data_out

Function
REQ-007 Divider SHALL free-run 0..CLK_DIV-1; tick SHALL be high for one clock when count = CLK_DIV-1.
REQ-008 sdat_in SHALL pass through a 2-flop synchroniser before use.
REQ-009 FSM states SHALL be IDLE, SETUP, SHIFT, CONV, LOAD.
REQ-010 IDLE: cs_n=1, adc_clk=0, busy=0; start=1 or continuous=1 SHALL latch channel into the address register and enter SETUP next clock.
REQ-011 SETUP: cs_n=0, busy=1, sdat_out=address MSB; after SETUP_TICKS ticks SHALL enter SHIFT.
REQ-012 SHIFT: DATA_BITS bit periods of two ticks each; adc_clk high on first tick, low on second.
REQ-013 Synchronised sdat_in SHALL be shifted in MSB first on the tick that drives adc_clk low.
REQ-014 sdat_out SHALL advance to the next address bit when adc_clk falls; after ADDR_BITS bits it SHALL be 0.
REQ-015 After bit DATA_BITS, FSM SHALL enter CONV with cs_n=1, adc_clk=0, for CONV_TICKS ticks.
REQ-016 LOAD: one clock; data_out <= shift register, chan_out <= address of the preceding frame (ADC pipelines one frame), data_valid=1.
REQ-017 LOAD SHALL go to SETUP if continuous=1, else IDLE.
REQ-018 start while busy=1 SHALL be ignored; continuous dropped mid-frame SHALL let the frame complete.
REQ-019 data_out/chan_out SHALL hold between LOAD strobes.
REQ-020 Frame SHALL complete within (SETUP_TICKS+2*DATA_BITS+CONV_TICKS+2)*CLK_DIV clocks of start.

Reset
REQ-021 reset SHALL force, next clock: IDLE, divider 0, cs_n=1, adc_clk=0, sdat_out=0, busy=0, data_valid=0, data_out=0, chan_out=0, address 0.
REQ-022 reset mid-frame SHALL abort without a data_valid strobe.

Configuration
REQ-023 With ADC_AUTOSCAN_EN defined, continuous frames SHALL use address+1 after each LOAD, wrapping NUM_CHANNELS-1 to 0; channel SHALL be sampled only on leaving IDLE.
REQ-024 Without ADC_AUTOSCAN_EN, channel SHALL be re-latched at every frame start.

Verification (CLK_DIV=4, DATA_BITS=12, ADDR_BITS=4, SETUP_TICKS=2, CONV_TICKS=10)
REQ-025 Single: channel=5, start pulse, model returns 0xA5C -> 12 adc_clk pulses, sdat_out 0101, one data_valid within 152 clocks, data_out=0xA5C.
REQ-026 Pipeline tag: frames on channel 3 then 7 -> second strobe chan_out=3.
REQ-027 Continuous, ADC_AUTOSCAN_EN, start channel 9, NUM_CHANNELS=11 -> frame addresses 9,10,0,1.
REQ-028 start pulsed during SHIFT -> ignored, exactly one data_valid.
REQ-029 reset asserted in SHIFT bit 6 -> next clock cs_n=1, adc_clk=0, busy=0, data_out=0, no strobe.
REQ-030 continuous dropped in CONV -> frame completes, one strobe, then IDLE with cs_n=1.
